// File: rtl/pipelined_data_path_if.sv
// Handshake bundle between the sequencer, the datapath and the result consumer.
// Upstream instruction channel and downstream result channel share one interface.
interface pipelined_data_path_if #(
  parameter int W  = 32,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic [AW-1:0] dest;
  logic [3:0]    opcode;
  logic          use_imm;
  logic [W-1:0]  imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_dest;
  logic [3:0]    flags;

  modport master (
    output in_valid, src1, src2, dest,
    output opcode, use_imm, imm, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_dest, flags
  );

  modport slave (
    input  in_valid, src1, src2, dest,
    input  opcode, use_imm, imm, out_ready,
    output in_ready, out_valid, out_data,
    output out_dest, flags
  );
endinterface

// File: rtl/pipelined_data_path.sv
// Register file + two-stage Execute/Writeback ALU pipeline with valid/ready.
// Define PDP_FORWARD_EN for RAW forwarding; otherwise dependents interlock.
module pipelined_data_path #(
  parameter int W    = 32,
  parameter int NREG = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_data_path_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(W);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_XOR, OP_NOT, OP_SLL, OP_SRL,
    OP_SRA, OP_SLT, OP_SLTU, OP_MOV,
    OP_INC, OP_DEC, OP_NOP0, OP_NOP1
  } op_e;

  typedef struct packed {
    logic          valid;
    op_e           op;
    logic [AW-1:0] dest;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } ex_t;

  logic [W-1:0] regs [NREG];
  ex_t          ex;

  logic          advance;
  logic          accept;
  logic          hit1;
  logic          hit2;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_rd;
  logic [W-1:0]  b_in;

  logic [W-1:0]  res;
  logic          c_f;
  logic          v_f;
  logic [W-1:0]  x;
  logic [W:0]    sum;
  logic [W:0]    dif;
  logic [SW-1:0] sh;

  assign advance = !bus.out_valid || bus.out_ready;

  assign hit1 = ex.valid
             && bus.src1 == ex.dest;
  assign hit2 = ex.valid && !bus.use_imm
             && bus.src2 == ex.dest;

`ifdef PDP_FORWARD_EN
  assign bus.in_ready = advance;
  assign a_in = hit1 ? res : regs[bus.src1];
  assign b_rd = hit2 ? res : regs[bus.src2];
`else
  assign bus.in_ready = advance
                     && !(hit1 || hit2);
  assign a_in = regs[bus.src1];
  assign b_rd = regs[bus.src2];
`endif

  assign b_in   = bus.use_imm ? bus.imm : b_rd;
  assign accept = bus.in_valid && bus.in_ready;

  // INC/DEC reuse the adder/subtractor with B forced to 1
  always_comb begin
    x = ex.b;
    if (ex.op == OP_INC || ex.op == OP_DEC)
      x = {{(W-1){1'b0}}, 1'b1};
    sum = {1'b0, ex.a} + {1'b0, x};
    dif = {1'b0, ex.a} - {1'b0, x};
    sh  = ex.b[SW-1:0];
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (ex.op)
      OP_ADD, OP_INC: begin
        res = sum[W-1:0];
        c_f = sum[W];
        v_f = (ex.a[W-1] == x[W-1])
           && (sum[W-1] != ex.a[W-1]);
      end
      OP_SUB, OP_DEC: begin
        res = dif[W-1:0];
        c_f = dif[W];
        v_f = (ex.a[W-1] != x[W-1])
           && (dif[W-1] != ex.a[W-1]);
      end
      OP_AND:  res = ex.a & ex.b;
      OP_OR:   res = ex.a | ex.b;
      OP_XOR:  res = ex.a ^ ex.b;
      OP_NOT:  res = ~ex.a;
      OP_SLL:  res = ex.a << sh;
      OP_SRL:  res = ex.a >> sh;
      OP_SRA:  res = $signed(ex.a) >>> sh;
      OP_SLT:  res = {{(W-1){1'b0}},
                 $signed(ex.a) < $signed(ex.b)};
      OP_SLTU: res = {{(W-1){1'b0}},
                 ex.a < ex.b};
      OP_MOV:  res = ex.b;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_dest  <= '0;
      bus.flags     <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (advance) begin
      bus.out_valid <= ex.valid;
      bus.out_data  <= res;
      bus.out_dest  <= ex.dest;
      bus.flags     <= {res[W-1], res == '0,
                        c_f, v_f};
      if (ex.valid)
        regs[ex.dest] <= res;
      ex.valid <= accept
               && bus.opcode[3:1] != 3'b111;
      if (accept) begin
        ex.op   <= op_e'(bus.opcode);
        ex.dest <= bus.dest;
        ex.a    <= a_in;
        ex.b    <= b_in;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_data_path.sv
// Self-checking bench: directed vector table, hand sequences, random vs model.
// Works with or without PDP_FORWARD_EN; only expected timing differs.
module tb_pipelined_data_path;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_data_path_if #(.W(32), .AW(4)) bus ();

  pipelined_data_path #(.W(32), .NREG(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  d;
    logic        ui;
    logic [31:0] imm;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  localparam longint MAXS = 64'sh7FFFFFFF;
  localparam longint MINS = -64'sh80000000;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int out_cnt = 0;
  logic [31:0] last_data;
  logic [3:0]  last_flags;
  logic [3:0]  last_dest;
  logic [31:0] out_d[$];
  int          out_c[$];
  exp_t        exp_q[$];
  logic [31:0] m_regs [16];

  logic rand_bp = 1'b0;
  logic rnd_rdy = 1'b1;
  logic ready_force = 1'b1;
  assign bus.out_ready = rand_bp ? rnd_rdy
                                 : ready_force;

  always @(posedge clk) cyc++;
  always @(negedge clk)
    rnd_rdy = ($urandom_range(0, 3) != 0);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  name, act, exp);
  endtask

  task automatic fail(input string name);
    n_tot++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t model(
    input logic [3:0] op,
    input logic [31:0] a, b,
    input logic [3:0] d);
    longint unsigned ua, ub, r;
    longint sa, sb, s;
    int sh;
    logic c, v;
    exp_t e;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sh = int'(b[4:0]);
    s = 0; r = 0; c = 0;
    case (op)
      4'd0:  begin r = ua + ub; c = r[32]; s = sa + sb; end
      4'd1:  begin r = ua - ub; c = ua < ub; s = sa - sb; end
      4'd12: begin r = ua + 1; c = r[32]; s = sa + 1; end
      4'd13: begin r = ua - 1; c = ua == 0; s = sa - 1; end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ~ua;
      4'd6:  r = ua << sh;
      4'd7:  r = ua >> sh;
      4'd8:  r = sa >>> sh;
      4'd9:  r = {63'b0, sa < sb};
      4'd10: r = {63'b0, ua < ub};
      default: r = ub;
    endcase
    v = (op == 4'd0 || op == 4'd1 ||
         op == 4'd12 || op == 4'd13) &&
        (s > MAXS || s < MINS);
    e.data  = r[31:0];
    e.dest  = d;
    e.flags = {e.data[31], e.data == 0, c, v};
    return e;
  endfunction

  task automatic issue(
    input logic [3:0] op, s1, s2, d,
    input logic ui, input logic [31:0] im);
    int n;
    logic [31:0] a, b;
    exp_t e;
    @(negedge clk);
    bus.opcode = op; bus.src1 = s1;
    bus.src2 = s2; bus.dest = d;
    bus.use_imm = ui; bus.imm = im;
    bus.in_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.in_ready) begin
      if (n == 200) begin
        fail("accept timeout");
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    a = m_regs[s1];
    b = ui ? im : m_regs[s2];
    if (op < 4'd14) begin
      e = model(op, a, b, d);
      m_regs[d] = e.data;
      exp_q.push_back(e);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (out_cnt < target && n < 100) begin
      @(negedge clk); #4; n++;
    end
    if (out_cnt < target) fail("output timeout");
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
    #4;
  endtask

  always @(negedge clk) begin
    #3;
    if (rst && bus.out_valid && bus.out_ready) begin
      exp_t e;
      out_cnt++;
      last_data  = bus.out_data;
      last_flags = bus.flags;
      last_dest  = bus.out_dest;
      out_d.push_back(bus.out_data);
      out_c.push_back(cyc);
      if (exp_q.size() == 0) fail("unexpected output");
      else begin
        e = exp_q.pop_front();
        chk("mon data", bus.out_data, e.data);
        chk("mon dest", 32'(bus.out_dest), 32'(e.dest));
        chk("mon flags", 32'(bus.flags), 32'(e.flags));
      end
    end
  end

  function automatic vec_t mk(
    input logic [3:0] op, s1, s2, d,
    input logic ui, input logic [31:0] im,
    input logic [31:0] data, input logic [3:0] fl);
    vec_t v;
    v.op = op; v.s1 = s1; v.s2 = s2; v.d = d;
    v.ui = ui; v.imm = im; v.data = data; v.flags = fl;
    return v;
  endfunction

  vec_t tv [21];
  int b;
  int gap;
  logic [31:0] spec_imm [5];

  initial begin
    // op, s1, s2, d, ui, imm, data, {N,Z,C,V}
    tv[0]  = mk(11, 0, 0, 1, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000);
    tv[1]  = mk(0,  1, 0, 2, 1, 32'h1,        32'h80000000, 4'b1001);
    tv[2]  = mk(11, 0, 0, 1, 1, 32'h0,        32'h0,        4'b0100);
    tv[3]  = mk(1,  1, 0, 2, 1, 32'h1,        32'hFFFFFFFF, 4'b1010);
    tv[4]  = mk(11, 0, 0, 4, 1, 32'h5,        32'h5,        4'b0000);
    tv[5]  = mk(1,  4, 0, 5, 1, 32'h5,        32'h0,        4'b0100);
    tv[6]  = mk(11, 0, 0, 6, 1, 32'h80000000, 32'h80000000, 4'b1000);
    tv[7]  = mk(8,  6, 0, 7, 1, 32'h4,        32'hF8000000, 4'b1000);
    tv[8]  = mk(7,  6, 0, 7, 1, 32'h4,        32'h08000000, 4'b0000);
    tv[9]  = mk(11, 0, 0, 8, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
    tv[10] = mk(9,  8, 0, 9, 1, 32'h1,        32'h1,        4'b0000);
    tv[11] = mk(10, 8, 0, 9, 1, 32'h1,        32'h0,        4'b0100);
    tv[12] = mk(12, 8, 0, 10, 1, 32'h0,       32'h0,        4'b0110);
    tv[13] = mk(13, 1, 0, 10, 1, 32'h0,       32'hFFFFFFFF, 4'b1010);
    tv[14] = mk(5,  1, 0, 11, 1, 32'h0,       32'hFFFFFFFF, 4'b1000);
    tv[15] = mk(1,  6, 0, 12, 1, 32'h1,       32'h7FFFFFFF, 4'b0001);
    tv[16] = mk(4,  8, 0, 13, 1, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b1000);
    tv[17] = mk(2, 13, 0, 13, 1, 32'hFF00FF00, 32'hF000F000, 4'b1000);
    tv[18] = mk(3,  4, 0, 14, 1, 32'h30,      32'h35,       4'b0000);
    tv[19] = mk(6, 14, 0, 14, 1, 32'd36,      32'h350,      4'b0000);
    tv[20] = mk(0,  8, 8, 15, 0, 32'h0,       32'hFFFFFFFE, 4'b1010);
    spec_imm[0] = 32'h0;
    spec_imm[1] = 32'h1;
    spec_imm[2] = 32'h7FFFFFFF;
    spec_imm[3] = 32'h80000000;
    spec_imm[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.opcode = '0;
    bus.src1 = '0; bus.src2 = '0; bus.dest = '0;
    bus.use_imm = 1'b0; bus.imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset flags", 32'(bus.flags), 0);
    chk("reset out_dest", 32'(bus.out_dest), 0);
    rst = 1'b1;
    #1 chk("reset in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 21; i++) begin
      b = out_cnt;
      issue(tv[i].op, tv[i].s1, tv[i].s2, tv[i].d,
            tv[i].ui, tv[i].imm);
      wait_cnt(b + 1);
      chk($sformatf("vec%0d data", i), last_data, tv[i].data);
      chk($sformatf("vec%0d flags", i),
          32'(last_flags), 32'(tv[i].flags));
      chk($sformatf("vec%0d dest", i),
          32'(last_dest), 32'(tv[i].d));
    end

    // back-to-back MOV, MOV, dependent ADD
    idle(2);
    out_d.delete(); out_c.delete();
    b = out_cnt;
    issue(11, 0, 0, 1, 1, 32'd5);
    issue(11, 0, 0, 2, 1, 32'd7);
    issue(0, 1, 2, 3, 0, 32'd0);
    wait_cnt(b + 3);
`ifdef PDP_FORWARD_EN
    gap = 1;
`else
    gap = 2;
`endif
    chk("lat count", 32'(out_d.size()), 3);
    if (out_d.size() == 3) begin
      chk("lat r1", out_d[0], 5);
      chk("lat r2", out_d[1], 7);
      chk("lat r3", out_d[2], 12);
      chk("lat gap01", 32'(out_c[1] - out_c[0]), 1);
      chk("lat gap12", 32'(out_c[2] - out_c[1]), 32'(gap));
    end

    // NOP must not write or produce output
    b = out_cnt;
    issue(14, 0, 0, 3, 1, 32'd99);
    repeat (3) begin
      @(negedge clk); #4;
      chk("nop out_valid", 32'(bus.out_valid), 0);
    end
    chk("nop no output", 32'(out_cnt), 32'(b));
    issue(11, 0, 3, 5, 0, 32'd0);
    wait_cnt(b + 1);
    chk("nop r3 kept", last_data, 12);

    // back-pressure with two instructions in flight
    idle(2);
    out_d.delete();
    b = out_cnt;
    ready_force = 1'b0;
    issue(11, 0, 0, 1, 1, 32'h11);
    issue(11, 0, 0, 2, 1, 32'h22);
    repeat (3) begin
      @(negedge clk);
      bus.opcode = 4'd0; bus.src1 = 4'd1;
      bus.src2 = 4'd2; bus.dest = 4'd3;
      bus.use_imm = 1'b0; bus.in_valid = 1'b1;
      #2;
      chk("bp in_ready", 32'(bus.in_ready), 0);
      chk("bp out_valid", 32'(bus.out_valid), 1);
      chk("bp out_data", bus.out_data, 32'h11);
    end
    bus.in_valid = 1'b0;
    ready_force = 1'b1;
    issue(0, 1, 2, 3, 0, 32'd0);
    wait_cnt(b + 3);
    idle(4);
    chk("bp count", 32'(out_cnt - b), 3);
    if (out_d.size() == 3) begin
      chk("bp first", out_d[0], 32'h11);
      chk("bp second", out_d[1], 32'h22);
      chk("bp third", out_d[2], 32'h33);
    end

    // reset mid-stream with in_valid held high
    ready_force = 1'b0;
    issue(11, 0, 0, 6, 1, 32'h55);
    issue(11, 0, 0, 7, 1, 32'h66);
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = 4'd11; bus.dest = 4'd8;
    bus.use_imm = 1'b1; bus.imm = 32'h77;
    bus.in_valid = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("mid rst out_valid", 32'(bus.out_valid), 0);
    chk("mid rst flags", 32'(bus.flags), 0);
    chk("mid rst out_data", bus.out_data, 0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    ready_force = 1'b1;
    #1 chk("mid rst in_ready", 32'(bus.in_ready), 1);
    b = out_cnt;
    issue(11, 0, 0, 3, 1, 32'd0);
    wait_cnt(b + 1);
    chk("mov0 data", last_data, 0);
    chk("mov0 flags", 32'(last_flags), 32'h4);
    issue(11, 0, 6, 9, 0, 32'd0);
    wait_cnt(b + 2);
    chk("reg cleared", last_data, 0);

    // random traffic with random back-pressure
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] im;
      if ($urandom_range(0, 3) == 0)
        im = spec_imm[$urandom_range(0, 4)];
      else
        im = $urandom;
      issue(4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), im);
    end
    for (int r = 0; r < 16; r++)
      issue(11, 0, 4'(r), 4'(r), 0, 32'd0);
    rand_bp = 1'b0;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++)
      idle(1);
    chk("drain empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
